// File: rtl/acorn128_pkg.sv
// Shared ACORN-128 constants, FSM encoding and boolean helpers used by the
// step function and the tag verifier.
package acorn128_pkg;

  localparam int unsigned ACORN_STATE_W     = 293;
  localparam int unsigned ACORN_TAG_W       = 128;
  localparam int unsigned ACORN_FINAL_STEPS = 768;
  localparam int unsigned ACORN_TAG_START   = 640;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_state_e;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic ch(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

endpackage

// File: rtl/acorn128_tag_verify_if.sv
// Request/verdict bundle between the decrypt datapath (master) and the tag
// verifier (slave).
interface acorn128_tag_verify_if;
  import acorn128_pkg::*;

  logic                     start;
  logic [ACORN_STATE_W-1:0] state_in;
  logic [ACORN_TAG_W-1:0]   tag_rx;
  logic                     busy;
  logic                     done;
  logic                     tag_ok;

  modport master (
    output start,
    output state_in,
    output tag_rx,
    input  busy,
    input  done,
    input  tag_ok
  );

  modport slave (
    input  start,
    input  state_in,
    input  tag_rx,
    output busy,
    output done,
    output tag_ok
  );

endinterface

// File: rtl/acorn128_step.sv
// One combinational ACORN-128 v3 state update; returns the next state and the
// keystream bit produced by this step.
module acorn128_step
  import acorn128_pkg::*;
(
  input  logic [ACORN_STATE_W-1:0] state,
  input  logic                     m,
  input  logic                     ca,
  input  logic                     cb,
  output logic [ACORN_STATE_W-1:0] state_nxt,
  output logic                     ks
);

  logic [ACORN_STATE_W-1:0] s;
  logic                     f;

  // Feedback updates are applied in order; later taps see earlier results.
  always_comb begin
    s      = state;
    s[289] = s[289] ^ s[235] ^ s[230];
    s[230] = s[230] ^ s[196] ^ s[193];
    s[193] = s[193] ^ s[160] ^ s[154];
    s[154] = s[154] ^ s[111] ^ s[107];
    s[107] = s[107] ^ s[66]  ^ s[61];
    s[61]  = s[61]  ^ s[23]  ^ s[0];

    ks = s[12] ^ s[154] ^ maj(s[235], s[61], s[193]) ^ ch(s[230], s[111], s[66]);
    f  = s[0] ^ ~s[107] ^ maj(s[244], s[23], s[160]) ^ (ca & s[196]) ^ (cb & ks);

    state_nxt = {f ^ m, s[ACORN_STATE_W-1:1]};
  end

endmodule

// File: rtl/acorn128_tag_verify.sv
// Runs the 768-step ACORN-128 finalization and compares the last 128 keystream
// bits against the received tag in constant time.
module acorn128_tag_verify
  import acorn128_pkg::*;
#(
  parameter int unsigned UNROLL = 1
) (
  input logic                  clk,
  input logic                  rst,
  acorn128_tag_verify_if.slave bus
);

  localparam int unsigned TagIdxW  = $clog2(ACORN_TAG_W);
  localparam logic [9:0]  StepInc  = 10'(UNROLL);
  localparam logic [9:0]  LastCnt  = 10'(ACORN_FINAL_STEPS - UNROLL);
  localparam logic [9:0]  TagStart = 10'(ACORN_TAG_START);

  if (!(UNROLL inside {1, 2, 4, 8})) begin : g_unroll_check
    $error("acorn128_tag_verify: UNROLL must be 1, 2, 4 or 8");
  end

  fsm_state_e               fsm_q, fsm_d;
  logic [ACORN_STATE_W-1:0] cipher_q, cipher_d;
  logic [ACORN_TAG_W-1:0]   tag_q, tag_d;
  logic [9:0]               step_cnt_q, step_cnt_d;
  logic                     diff_q, diff_d;
  logic                     tag_ok_q, tag_ok_d;

  logic [ACORN_STATE_W-1:0] step_out;
  logic [UNROLL-1:0]        ks_vec;
  logic                     diff_acc;
  logic                     last_step;
  logic [9:0]               step_idx;

  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    logic [ACORN_STATE_W-1:0] st_in;
    logic [ACORN_STATE_W-1:0] st_out;

    if (g == 0) begin : g_first
      assign st_in = cipher_q;
    end else begin : g_chain
      assign st_in = g_step[g-1].st_out;
    end

    acorn128_step u_step (
      .state     (st_in),
      .m         (1'b0),
      .ca        (1'b1),
      .cb        (1'b1),
      .state_nxt (st_out),
      .ks        (ks_vec[g])
    );
  end

  assign step_out  = g_step[UNROLL-1].st_out;
  assign last_step = (step_cnt_q == LastCnt);

  // ACORN_TAG_START is a multiple of ACORN_TAG_W, so the low index bits are
  // the tag bit offset directly.
  always_comb begin
    diff_acc = diff_q;
    step_idx = '0;
    for (int unsigned j = 0; j < UNROLL; j++) begin
      step_idx = step_cnt_q + 10'(j);
      if (step_idx >= TagStart) begin
        diff_acc = diff_acc | (ks_vec[j] ^ tag_q[step_idx[TagIdxW-1:0]]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE:    if (bus.start) fsm_d = RUN;
      RUN:     if (last_step) fsm_d = DONE;
      DONE:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy   = (fsm_q == RUN);
    bus.done   = (fsm_q == DONE);
    bus.tag_ok = tag_ok_q;
  end

  // Datapath next state; state and tag are wiped on the final step.
  always_comb begin
    cipher_d   = cipher_q;
    tag_d      = tag_q;
    step_cnt_d = step_cnt_q;
    diff_d     = diff_q;
    tag_ok_d   = tag_ok_q;
    unique case (fsm_q)
      IDLE: begin
        if (bus.start) begin
          cipher_d   = bus.state_in;
          tag_d      = bus.tag_rx;
          step_cnt_d = '0;
          diff_d     = 1'b0;
          tag_ok_d   = 1'b0;
        end
      end
      RUN: begin
        step_cnt_d = step_cnt_q + StepInc;
        diff_d     = diff_acc;
        if (last_step) begin
          cipher_d = '0;
          tag_d    = '0;
          tag_ok_d = ~diff_acc;
        end else begin
          cipher_d = step_out;
        end
      end
      default: begin
        cipher_d = '0;
        tag_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cipher_q   <= '0;
      tag_q      <= '0;
      step_cnt_q <= '0;
      diff_q     <= 1'b0;
      tag_ok_q   <= 1'b0;
    end else begin
      cipher_q   <= cipher_d;
      tag_q      <= tag_d;
      step_cnt_q <= step_cnt_d;
      diff_q     <= diff_d;
      tag_ok_q   <= tag_ok_d;
    end
  end

endmodule

// File: tb/tb_acorn128_tag_verify.sv
// Self-checking bench for acorn128_tag_verify: UNROLL=1 and UNROLL=8 instances
// checked against a behavioural ACORN-128 finalization model via a scoreboard.
module tb_acorn128_tag_verify;
  import acorn128_pkg::*;

  localparam int Bound = 2000;

  typedef struct {
    bit    ok;
    int    lat;
    string name;
  } sb_item_t;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  sb_item_t    sb1[$];
  sb_item_t    sb8[$];

  acorn128_tag_verify_if vif1 ();
  acorn128_tag_verify_if vif8 ();

  always #5 clk = ~clk;

  acorn128_tag_verify #(.UNROLL(1)) dut1 (.clk(clk), .rst(rst), .bus(vif1));
  acorn128_tag_verify #(.UNROLL(8)) dut8 (.clk(clk), .rst(rst), .bus(vif8));

  function automatic bit [292:0] model_step(input bit [292:0] s_in, output bit ks);
    bit [292:0] s;
    bit a, b, c, f;
    s = s_in;
    s[289] ^= s[235] ^ s[230];
    s[230] ^= s[196] ^ s[193];
    s[193] ^= s[160] ^ s[154];
    s[154] ^= s[111] ^ s[107];
    s[107] ^= s[66] ^ s[61];
    s[61]  ^= s[23] ^ s[0];
    a = s[235]; b = s[61]; c = s[193];
    ks = s[12] ^ s[154] ^ ((a & b) | (a & c) | (b & c)) ^ (s[230] ? s[111] : s[66]);
    a = s[244]; b = s[23]; c = s[160];
    f = s[0] ^ !s[107] ^ ((a & b) | (a & c) | (b & c)) ^ s[196] ^ ks;
    return {f, s[292:1]};
  endfunction

  function automatic bit [127:0] model_tag(input bit [292:0] st);
    bit [292:0] s = st;
    bit         k;
    bit [127:0] t = '0;
    for (int i = 0; i < 768; i++) begin
      s = model_step(s, k);
      if (i >= 640) t[i-640] = k;
    end
    return t;
  endfunction

  // Called at a negedge; start spans exactly one posedge (edge 0).
  task automatic drive_start(input bit u8, input logic [292:0] st, input logic [127:0] tg,
                             input string name);
    sb_item_t it;
    it.ok   = (tg == model_tag(st));
    it.lat  = u8 ? 96 : 768;
    it.name = name;
    if (u8) begin
      vif8.start = 1'b1; vif8.state_in = st; vif8.tag_rx = tg;
      sb8.push_back(it);
    end else begin
      vif1.start = 1'b1; vif1.state_in = st; vif1.tag_rx = tg;
      sb1.push_back(it);
    end
    @(posedge clk);
    @(negedge clk);
    if (u8) vif8.start = 1'b0;
    else vif1.start = 1'b0;
  endtask

  task automatic wait_done(input bit u8, output int lat, output int bcnt, output bit to);
    bit dn;
    lat  = 0;
    to   = 1'b0;
    dn   = 1'b0;
    bcnt = u8 ? int'(vif8.busy) : int'(vif1.busy);
    while (!dn && !to) begin
      @(negedge clk);
      lat++;
      dn = u8 ? vif8.done : vif1.done;
      if (!dn && (u8 ? vif8.busy : vif1.busy)) bcnt++;
      if (lat >= Bound) to = 1'b1;
    end
  endtask

  function automatic bit [292:0] rand_state();
    bit [292:0] s;
    for (int i = 0; i < 293; i++) s[i] = 1'($urandom_range(0, 1));
    return s;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    vif1.start = 1'b0; vif1.state_in = '0; vif1.tag_rx = '0;
    vif8.start = 1'b0; vif8.state_in = '0; vif8.tag_rx = '0;
    repeat (3) @(negedge clk);
    n_chk++; if (vif1.busy !== 1'b0) $display("FAIL reset busy1: got %b want 0", vif1.busy);
    else n_pass++;
    n_chk++; if (vif1.done !== 1'b0) $display("FAIL reset done1: got %b want 0", vif1.done);
    else n_pass++;
    n_chk++; if (vif1.tag_ok !== 1'b0) $display("FAIL reset tag_ok1: got %b want 0", vif1.tag_ok);
    else n_pass++;
    n_chk++; if ({vif8.busy, vif8.done, vif8.tag_ok} !== 3'b000)
      $display("FAIL reset outs8: got %b want 000", {vif8.busy, vif8.done, vif8.tag_ok});
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_state();
    int lat, bcnt; bit to; sb_item_t it;
    drive_start(1'b0, '0, model_tag('0), "zero");
    wait_done(1'b0, lat, bcnt, to);
    it = sb1.pop_front();
    n_chk++; if (to || vif1.tag_ok !== it.ok)
      $display("FAIL %s tag_ok: got %b want %b (timeout %b)", it.name, vif1.tag_ok, it.ok, to);
    else n_pass++;
    n_chk++; if (lat != it.lat) $display("FAIL %s latency: got %0d want %0d", it.name, lat, it.lat);
    else n_pass++;
    n_chk++; if (bcnt != 768) $display("FAIL %s busy cycles: got %0d want 768", it.name, bcnt);
    else n_pass++;
    @(negedge clk);
    n_chk++; if (vif1.done !== 1'b0) $display("FAIL %s done pulse width: got %b want 0", it.name,
                                             vif1.done);
    else n_pass++;
    repeat (4) @(negedge clk);
    n_chk++; if (vif1.tag_ok !== 1'b1 || vif1.busy !== 1'b0)
      $display("FAIL %s held verdict: got ok=%b busy=%b want ok=1 busy=0", it.name, vif1.tag_ok,
               vif1.busy);
    else n_pass++;
  endtask

  task automatic test_tag_flip();
    int lat, bcnt; bit to; sb_item_t it; bit [127:0] good, bad;
    good = model_tag('0);
    for (int k = 0; k < 2; k++) begin
      bad = good;
      bad[k == 0 ? 0 : 127] = ~bad[k == 0 ? 0 : 127];
      drive_start(1'b0, '0, bad, k == 0 ? "flip0" : "flip127");
      wait_done(1'b0, lat, bcnt, to);
      it = sb1.pop_front();
      n_chk++; if (to || vif1.tag_ok !== it.ok)
        $display("FAIL %s tag_ok: got %b want %b (timeout %b)", it.name, vif1.tag_ok, it.ok, to);
      else n_pass++;
      n_chk++; if (lat != it.lat) $display("FAIL %s latency: got %0d want %0d", it.name, lat,
                                           it.lat);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_unroll8();
    int lat, bcnt; bit to; sb_item_t it; bit [292:0] st; bit [127:0] tg;
    void'($urandom(32'h1234));
    st = rand_state();
    tg = model_tag(st);
    for (int k = 0; k < 3; k++) begin
      bit u8 = (k != 1);
      bit [127:0] t = (k == 2) ? (tg ^ (128'd1 << 64)) : tg;
      drive_start(u8, st, t, k == 0 ? "u8_good" : (k == 1 ? "u1_rand" : "u8_bad"));
      wait_done(u8, lat, bcnt, to);
      it = u8 ? sb8.pop_front() : sb1.pop_front();
      n_chk++; if (to || (u8 ? vif8.tag_ok : vif1.tag_ok) !== it.ok)
        $display("FAIL %s tag_ok: got %b want %b (timeout %b)", it.name,
                 u8 ? vif8.tag_ok : vif1.tag_ok, it.ok, to);
      else n_pass++;
      n_chk++; if (lat != it.lat) $display("FAIL %s latency: got %0d want %0d", it.name, lat,
                                           it.lat);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_start_ignored();
    int lat, bcnt, extra_done; bit to; sb_item_t it; bit [292:0] st;
    st = rand_state();
    drive_start(1'b0, st, model_tag(st), "ignored");
    repeat (10) @(negedge clk);
    vif1.start = 1'b1; vif1.state_in = rand_state(); vif1.tag_rx = ~model_tag(st);
    @(posedge clk);
    @(negedge clk);
    vif1.start = 1'b0;
    wait_done(1'b0, lat, bcnt, to);
    it = sb1.pop_front();
    n_chk++; if (to || vif1.tag_ok !== it.ok)
      $display("FAIL %s tag_ok: got %b want %b (timeout %b)", it.name, vif1.tag_ok, it.ok, to);
    else n_pass++;
    n_chk++; if (lat + 11 != it.lat) $display("FAIL %s latency: got %0d want %0d", it.name,
                                              lat + 11, it.lat);
    else n_pass++;
    extra_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (vif1.done || vif1.busy) extra_done++;
    end
    n_chk++; if (extra_done != 0) $display("FAIL %s queued run: got %0d active cycles want 0",
                                           it.name, extra_done);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int lat, bcnt; bit to; sb_item_t it;
    drive_start(1'b0, '0, model_tag('0), "abort");
    repeat (299) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_chk++; if ({vif1.busy, vif1.done, vif1.tag_ok} !== 3'b000)
      $display("FAIL abort outputs: got %b want 000", {vif1.busy, vif1.done, vif1.tag_ok});
    else n_pass++;
    sb1.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive_start(1'b0, '0, model_tag('0), "after_abort");
    wait_done(1'b0, lat, bcnt, to);
    it = sb1.pop_front();
    n_chk++; if (to || vif1.tag_ok !== it.ok)
      $display("FAIL %s tag_ok: got %b want %b (timeout %b)", it.name, vif1.tag_ok, it.ok, to);
    else n_pass++;
    n_chk++; if (lat != it.lat) $display("FAIL %s latency: got %0d want %0d", it.name, lat, it.lat);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, bcnt; bit to; sb_item_t it; bit [127:0] bad;
    bad = model_tag('0) ^ (128'd1 << 50);
    drive_start(1'b0, '0, model_tag('0), "b2b_first");
    wait_done(1'b0, lat, bcnt, to);
    it = sb1.pop_front();
    n_chk++; if (to || vif1.tag_ok !== it.ok)
      $display("FAIL %s tag_ok: got %b want %b (timeout %b)", it.name, vif1.tag_ok, it.ok, to);
    else n_pass++;
    // Start raised while in DONE must be ignored, then accepted in IDLE.
    vif1.start = 1'b1; vif1.state_in = '0; vif1.tag_rx = bad;
    @(posedge clk);
    @(negedge clk);
    n_chk++; if (vif1.busy !== 1'b0 || vif1.tag_ok !== 1'b1)
      $display("FAIL b2b start in DONE: got busy=%b ok=%b want busy=0 ok=1", vif1.busy,
               vif1.tag_ok);
    else n_pass++;
    it.ok = (bad == model_tag('0)); it.lat = 768; it.name = "b2b_second";
    sb1.push_back(it);
    @(posedge clk);
    @(negedge clk);
    vif1.start = 1'b0;
    n_chk++; if (vif1.busy !== 1'b1 || vif1.tag_ok !== 1'b0)
      $display("FAIL b2b accept: got busy=%b ok=%b want busy=1 ok=0", vif1.busy, vif1.tag_ok);
    else n_pass++;
    wait_done(1'b0, lat, bcnt, to);
    it = sb1.pop_front();
    n_chk++; if (to || vif1.tag_ok !== it.ok)
      $display("FAIL %s tag_ok: got %b want %b (timeout %b)", it.name, vif1.tag_ok, it.ok, to);
    else n_pass++;
    n_chk++; if (lat != it.lat) $display("FAIL %s latency: got %0d want %0d", it.name, lat, it.lat);
    else n_pass++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_state();
    test_tag_flip();
    test_unroll8();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
